// File: rtl/hilo_mul_ctrl_if.sv
// rtl/hilo_mul_ctrl_if.sv - request/result bundle between EX stage and the HI/LO sequencer
interface hilo_mul_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, abort, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, abort, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_mul_ctrl.sv
// rtl/hilo_mul_ctrl.sv - HI/LO owner: iterative shift-add MULT/MULTU/MADD/MSUB plus MTHI/MTLO
// RADIX_BITS multiplier bits are retired per MUL cycle (1, 2 or 4).
module hilo_mul_ctrl #(
  parameter int RADIX_BITS = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  hilo_mul_ctrl_if.slave bus
);

  localparam int NCYC = 32 / RADIX_BITS;
  localparam int CW   = $clog2(NCYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MSUB  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_e;

  state_e        state_q;
  logic [2:0]    op_q;
  logic [63:0]   mcand_q;
  logic [31:0]   mplier_q;
  logic [63:0]   prod_q;
  logic          neg_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          busy_q;
  logic          done_q;

  logic          signed_op;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [63:0]   pp_sum;
  logic [63:0]   prod_d;
  logic [63:0]   p_signed;
  logic [63:0]   hilo_d;

  always_comb begin
    signed_op = (bus.op != OP_MULTU);
    a_mag     = (signed_op && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    b_mag     = (signed_op && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
  end

  // Partial products for the low RADIX_BITS multiplier bits; mcand_q is pre-shifted each cycle.
  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < RADIX_BITS; j++) begin
      if (mplier_q[j]) begin
        pp_sum = pp_sum + (mcand_q << j);
      end
    end
    prod_d = prod_q + pp_sum;
  end

  always_comb begin
    p_signed = neg_q ? (~prod_q + 64'd1) : prod_q;
    case (op_q)
      OP_MADD: hilo_d = {hi_q, lo_q} + p_signed;
      OP_MSUB: hilo_d = {hi_q, lo_q} - p_signed;
      default: hilo_d = p_signed;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A flush in the same cycle wins over any request, including MTHI/MTLO.
          if (bus.start && !bus.abort) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                op_q     <= bus.op;
                mcand_q  <= {32'd0, a_mag};
                mplier_q <= b_mag;
                neg_q    <= signed_op & (bus.a[31] ^ bus.b[31]);
                prod_q   <= '0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= MUL;
              end
              OP_MTHI: begin
                hi_q   <= bus.a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << RADIX_BITS;
            mplier_q <= mplier_q >> RADIX_BITS;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CW'(NCYC - 1)) begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (!bus.abort) begin
            {hi_q, lo_q} <= hilo_d;
            done_q       <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// tb/tb_hilo_mul_ctrl.sv - bench for hilo_mul_ctrl: cycle model compare plus directed literal checks
module tb_hilo_mul_ctrl;

  localparam int NCYC = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hilo_mul_ctrl_if bi ();
  hilo_mul_ctrl_if b4 ();

  hilo_mul_ctrl #(.RADIX_BITS(1)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bi));
  hilo_mul_ctrl #(.RADIX_BITS(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(b4));

  int total = 0;
  int bad = 0;

  // Model: architectural HI/LO, a busy flag and a countdown to the commit edge.
  logic               m_busy = 1'b0;
  logic               m_done = 1'b0;
  logic [31:0]        m_hi = '0;
  logic [31:0]        m_lo = '0;
  logic [2:0]         m_op = '0;
  logic [63:0]        m_prod = '0;
  int                 m_left = 0;
  logic signed [63:0] sa, sb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (bi.abort) m_busy = 1'b0;
        else if (m_left == 0) begin
          case (m_op)
            3'd2:    {m_hi, m_lo} = {m_hi, m_lo} + m_prod;
            3'd3:    {m_hi, m_lo} = {m_hi, m_lo} - m_prod;
            default: {m_hi, m_lo} = m_prod;
          endcase
          m_done = 1'b1;
          m_busy = 1'b0;
        end else m_left--;
      end else if (bi.start && !bi.abort) begin
        case (bi.op)
          3'd0, 3'd2, 3'd3: begin
            sa = $signed(bi.a); sb = $signed(bi.b);
            m_prod = sa * sb;
            m_op = bi.op; m_busy = 1'b1; m_left = NCYC;
          end
          3'd1: begin
            m_prod = {32'd0, bi.a} * {32'd0, bi.b};
            m_op = bi.op; m_busy = 1'b1; m_left = NCYC;
          end
          3'd4: begin m_hi = bi.a; m_done = 1'b1; end
          3'd5: begin m_lo = bi.a; m_done = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    total++;
    if ({bi.busy, bi.done, bi.hi, bi.lo} !== {m_busy, m_done, m_hi, m_lo}) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t dut busy=%b done=%b hi=%h lo=%h model busy=%b done=%b hi=%h lo=%h",
               $time, bi.busy, bi.done, bi.hi, bi.lo, m_busy, m_done, m_hi, m_lo);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bi.start = 1'b1; bi.op = op; bi.a = a; bi.b = b;
    @(negedge clk);
    bi.start = 1'b0; bi.a = $urandom; bi.b = $urandom;
  endtask

  task automatic wait_done(input string name, output int e, output int bc);
    e = 0;
    bc = bi.busy ? 1 : 0;
    while (e < 100) begin
      @(negedge clk);
      e++;
      if (bi.busy) bc++;
      if (bi.done) break;
    end
    chk({name, "_done_seen"}, {63'd0, bi.done}, 64'd1);
  endtask

  task automatic issue4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int e);
    b4.start = 1'b1; b4.op = op; b4.a = a; b4.b = b;
    @(negedge clk);
    b4.start = 1'b0; b4.a = $urandom; b4.b = $urandom;
    e = 0;
    while (e < 100) begin
      @(negedge clk);
      e++;
      if (b4.done) break;
    end
    chk("r4_done_seen", {63'd0, b4.done}, 64'd1);
  endtask

  task automatic count_dones(input int n, output int nd);
    nd = 0;
    repeat (n) begin
      @(negedge clk);
      if (bi.done) nd++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, bc, nd;
    bi.start = 0; bi.op = 0; bi.a = 0; bi.b = 0; bi.abort = 0;
    b4.start = 0; b4.op = 0; b4.a = 0; b4.b = 0; b4.abort = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_hilo", {bi.hi, bi.lo}, 64'd0);
    chk("reset_busy_done", {62'd0, bi.busy, bi.done}, 64'd0);

    issue(3'd0, 32'hFFFFFFF9, 32'd3);
    wait_done("mult_neg", e, bc);
    chk("mult_neg_edge", e, 64'd33);
    chk("mult_neg_busy_cycles", bc, 64'd33);
    chk("mult_neg_hilo", {bi.hi, bi.lo}, 64'hFFFFFFFF_FFFFFFEB);
    chk("model_pin_hilo", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, bi.done}, 64'd0);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", e, bc);
    chk("multu_max_hilo", {bi.hi, bi.lo}, 64'hFFFFFFFE_00000001);
    @(negedge clk);
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mult_m1", e, bc);
    chk("mult_m1_hilo", {bi.hi, bi.lo}, 64'h00000000_00000001);
    @(negedge clk);

    issue(3'd4, 32'd0, 32'd0);
    chk("mthi_done", {63'd0, bi.done}, 64'd1);
    chk("mthi_busy", {63'd0, bi.busy}, 64'd0);
    issue(3'd5, 32'd10, 32'd0);
    chk("mtlo_hilo", {bi.hi, bi.lo}, 64'd10);
    @(negedge clk);
    issue(3'd2, 32'd2, 32'd3);
    wait_done("madd", e, bc);
    chk("madd_hilo", {bi.hi, bi.lo}, 64'd16);
    @(negedge clk);
    issue(3'd3, 32'd4, 32'd5);
    wait_done("msub", e, bc);
    chk("msub_hilo", {bi.hi, bi.lo}, 64'hFFFFFFFF_FFFFFFFC);
    chk("model_pin_msub", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFFC);
    @(negedge clk);

    issue(3'd0, 32'd100, 32'hFFFFFFFD);
    repeat (4) @(negedge clk);
    bi.start = 1'b1; bi.op = 3'd1; bi.a = 32'd5; bi.b = 32'd5;
    @(negedge clk);
    bi.start = 1'b0;
    wait_done("start_ignored", e, bc);
    chk("start_ignored_edge", e, 64'd28);
    chk("start_ignored_hilo", {bi.hi, bi.lo}, 64'hFFFFFFFF_FFFFFED4);
    count_dones(40, nd);
    chk("start_ignored_single_done", nd, 64'd0);

    issue(3'd4, 32'h1234, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    issue(3'd0, 32'd3, 32'd3);
    repeat (19) @(negedge clk);
    bi.abort = 1'b1;
    @(negedge clk);
    bi.abort = 1'b0;
    chk("abort_mul_busy", {62'd0, bi.busy, bi.done}, 64'd0);
    count_dones(40, nd);
    chk("abort_mul_no_done", nd, 64'd0);
    chk("abort_mul_hilo", {bi.hi, bi.lo}, 64'h00001234_00005678);

    issue(3'd1, 32'd2, 32'd2);
    repeat (32) @(negedge clk);
    bi.abort = 1'b1;
    @(negedge clk);
    bi.abort = 1'b0;
    chk("abort_acc_busy_done", {62'd0, bi.busy, bi.done}, 64'd0);
    count_dones(5, nd);
    chk("abort_acc_no_done", nd, 64'd0);
    chk("abort_acc_hilo", {bi.hi, bi.lo}, 64'h00001234_00005678);

    bi.start = 1'b1; bi.op = 3'd4; bi.a = 32'hDEAD; bi.abort = 1'b1;
    @(negedge clk);
    bi.start = 1'b0; bi.abort = 1'b0;
    chk("idle_abort_done", {63'd0, bi.done}, 64'd0);
    chk("idle_abort_hi", {32'd0, bi.hi}, 64'h1234);

    for (int k = 6; k < 8; k++) begin
      bi.start = 1'b1; bi.op = 3'(k); bi.a = 32'hBEEF;
      @(negedge clk);
      bi.start = 1'b0;
      chk("reserved_op", {62'd0, bi.busy, bi.done}, 64'd0);
    end

    issue(3'd0, 32'd7, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_hilo", {bi.hi, bi.lo}, 64'd0);
    chk("reset_mid_busy", {63'd0, bi.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue4(3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, e);
    chk("r4_edge", e, 64'd9);
    chk("r4_hilo", {b4.hi, b4.lo}, 64'h3FFFFFFF_00000001);
    @(negedge clk);
    issue4(3'd0, 32'hFFFFFFF9, 32'd3, e);
    chk("r4_neg_hilo", {b4.hi, b4.lo}, 64'hFFFFFFFF_FFFFFFEB);
    @(negedge clk);
    issue4(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, e);
    chk("r4_multu_hilo", {b4.hi, b4.lo}, 64'hFFFFFFFE_00000001);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
